dmem_port_arbiter: RTL and testbench

Two-requester arbiter and access sequencer for the byte-addressable data memory. Shares the single memory port between the core load/store path (port 0) and the program/debug loader (port 1) using round-robin arbitration and a valid/ready request handshake. Each access is registered, checked for alignment and size legality, driven onto the memory port for one cycle, and answered with a one-cycle response pulse to the owning requester.

---
 rtl/dmem_pkg.sv | 40 ++++
 rtl/rr_arb2.sv | 22 ++
 rtl/dmem_port_arbiter.sv | 160 ++++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// ============================================================================
// Module : dmem_pkg
// Brief  : Size encodings, sequencer state and access legality check shared
//          by the data-memory port logic.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package dmem_pkg;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    // Only the two address LSBs matter for natural alignment.
    function automatic logic dmem_access_err(input logic       write,
                                             input logic [2:0] size,
                                             input logic [1:0] addr);
        logic r;
        case (size)
            SZ_B:    r = 1'b0;
            SZ_BU:   r = write;
            SZ_H:    r = addr[0];
            SZ_HU:   r = write | addr[0];
            SZ_W:    r = (addr != 2'b00);
            default: r = 1'b1;
        endcase
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================================
// Module : rr_arb2
// Brief  : Two-way round-robin grant; prio names the port that wins a tie.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rr_arb2 (
    input  logic en,
    input  logic req0,
    input  logic req1,
    input  logic prio,
    output logic gnt0,
    output logic gnt1
);

    assign gnt0 = en & req0 & (~req1 | ~prio);
    assign gnt1 = en & req1 & (~req0 |  prio);

endmodule

`default_nettype wire

// File: rtl/dmem_port_arbiter.sv
// ============================================================================
// Module : dmem_port_arbiter
// Brief  : Shares the data-memory port between two valid/ready requesters,
//          one registered access every two cycles with a one-cycle response.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module dmem_port_arbiter
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  m0_req_valid,
    output logic                  m0_req_ready,
    input  logic                  m0_req_write,
    input  logic [2:0]            m0_req_size,
    input  logic [ADDR_WIDTH-1:0] m0_req_addr,
    input  logic [DATA_WIDTH-1:0] m0_req_wdata,
    output logic                  m0_rsp_valid,
    output logic [DATA_WIDTH-1:0] m0_rsp_rdata,
    output logic                  m0_rsp_err,

    input  logic                  m1_req_valid,
    output logic                  m1_req_ready,
    input  logic                  m1_req_write,
    input  logic [2:0]            m1_req_size,
    input  logic [ADDR_WIDTH-1:0] m1_req_addr,
    input  logic [DATA_WIDTH-1:0] m1_req_wdata,
    output logic                  m1_rsp_valid,
    output logic [DATA_WIDTH-1:0] m1_rsp_rdata,
    output logic                  m1_rsp_err,

    output logic [2:0]            mem_size,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_write,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_prio;

    logic                  r_cmd_write;
    logic                  r_cmd_owner;
    logic                  r_cmd_err;
    logic [2:0]            r_cmd_size;
    logic [ADDR_WIDTH-1:0] r_cmd_addr;
    logic [DATA_WIDTH-1:0] r_cmd_wdata;

    logic                  r_rsp_valid;
    logic                  r_rsp_owner;
    logic                  r_rsp_err;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;

    logic                  w_idle;
    logic                  w_access;
    logic                  w_gnt0;
    logic                  w_gnt1;
    logic                  w_accept;
    logic                  w_sel_write;
    logic [2:0]            w_sel_size;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;

    assign w_idle   = (r_state == ST_IDLE);
    assign w_access = (r_state == ST_ACCESS);

    rr_arb2 u_arb (
        .en   (w_idle),
        .req0 (m0_req_valid),
        .req1 (m1_req_valid),
        .prio (r_prio),
        .gnt0 (w_gnt0),
        .gnt1 (w_gnt1)
    );

    assign w_accept    = w_gnt0 | w_gnt1;
    assign w_sel_write = w_gnt1 ? m1_req_write : m0_req_write;
    assign w_sel_size  = w_gnt1 ? m1_req_size  : m0_req_size;
    assign w_sel_addr  = w_gnt1 ? m1_req_addr  : m0_req_addr;
    assign w_sel_wdata = w_gnt1 ? m1_req_wdata : m0_req_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept) w_state_next = ST_ACCESS;
            ST_ACCESS: w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // Command register: legality is resolved at acceptance so ACCESS only gates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio      <= 1'b0;
            r_cmd_write <= 1'b0;
            r_cmd_owner <= 1'b0;
            r_cmd_err   <= 1'b0;
            r_cmd_size  <= '0;
            r_cmd_addr  <= '0;
            r_cmd_wdata <= '0;
        end else if (w_accept) begin
            r_prio      <= ~w_gnt1;
            r_cmd_write <= w_sel_write;
            r_cmd_owner <= w_gnt1;
            r_cmd_err   <= dmem_access_err(w_sel_write, w_sel_size, w_sel_addr[1:0]);
            r_cmd_size  <= w_sel_size;
            r_cmd_addr  <= w_sel_addr;
            r_cmd_wdata <= w_sel_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_owner <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= w_access;
            if (w_access) begin
                r_rsp_owner <= r_cmd_owner;
                r_rsp_err   <= r_cmd_err;
                r_rsp_rdata <= (r_cmd_write | r_cmd_err) ? '0 : mem_rdata;
            end
        end
    end

    assign m0_req_ready = w_gnt0;
    assign m1_req_ready = w_gnt1;

    assign mem_size  = r_cmd_size;
    assign mem_addr  = r_cmd_addr;
    assign mem_wdata = r_cmd_wdata;
    assign mem_write = w_access & r_cmd_write & ~r_cmd_err;

    assign m0_rsp_valid = r_rsp_valid & ~r_rsp_owner;
    assign m1_rsp_valid = r_rsp_valid &  r_rsp_owner;
    assign m0_rsp_err   = m0_rsp_valid & r_rsp_err;
    assign m1_rsp_err   = m1_rsp_valid & r_rsp_err;
    assign m0_rsp_rdata = m0_rsp_valid ? r_rsp_rdata : '0;
    assign m1_rsp_rdata = m1_rsp_valid ? r_rsp_rdata : '0;

endmodule

`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
// ============================================================================
// Module : tb_dmem_port_arbiter
// Brief  : Self-checking bench: directed vector table, arbitration and reset
//          sequences, and random accesses against a byte-array reference.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_dmem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        m0_req_valid, m0_req_ready, m0_req_write;
    logic [2:0]  m0_req_size;
    logic [11:0] m0_req_addr;
    logic [31:0] m0_req_wdata;
    logic        m0_rsp_valid, m0_rsp_err;
    logic [31:0] m0_rsp_rdata;
    logic        m1_req_valid, m1_req_ready, m1_req_write;
    logic [2:0]  m1_req_size;
    logic [11:0] m1_req_addr;
    logic [31:0] m1_req_wdata;
    logic        m1_rsp_valid, m1_rsp_err;
    logic [31:0] m1_rsp_rdata;
    logic [2:0]  mem_size;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_write;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem     [0:4095];
    logic [7:0] ref_mem [0:4095];

    dmem_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready),
        .m0_req_write(m0_req_write), .m0_req_size(m0_req_size),
        .m0_req_addr(m0_req_addr), .m0_req_wdata(m0_req_wdata),
        .m0_rsp_valid(m0_rsp_valid), .m0_rsp_rdata(m0_rsp_rdata), .m0_rsp_err(m0_rsp_err),
        .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready),
        .m1_req_write(m1_req_write), .m1_req_size(m1_req_size),
        .m1_req_addr(m1_req_addr), .m1_req_wdata(m1_req_wdata),
        .m1_rsp_valid(m1_rsp_valid), .m1_rsp_rdata(m1_rsp_rdata), .m1_rsp_err(m1_rsp_err),
        .mem_size(mem_size), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_write(mem_write), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Physical memory: little-endian bytes, extended combinational read.
    always_comb begin
        logic [7:0] b0, b1, b2, b3;
        b0 = mem[mem_addr];
        b1 = mem[mem_addr + 12'd1];
        b2 = mem[mem_addr + 12'd2];
        b3 = mem[mem_addr + 12'd3];
        case (mem_size)
            3'b000:  mem_rdata = {{24{b0[7]}}, b0};
            3'b001:  mem_rdata = {{16{b1[7]}}, b1, b0};
            3'b100:  mem_rdata = {24'd0, b0};
            3'b101:  mem_rdata = {16'd0, b1, b0};
            default: mem_rdata = {b3, b2, b1, b0};
        endcase
    end

    always @(posedge clk) begin
        if (mem_write) begin
            mem[mem_addr] <= mem_wdata[7:0];
            if (mem_size[0] || mem_size[1]) mem[mem_addr + 12'd1] <= mem_wdata[15:8];
            if (mem_size[1]) begin
                mem[mem_addr + 12'd2] <= mem_wdata[23:16];
                mem[mem_addr + 12'd3] <= mem_wdata[31:24];
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic int nbytes(input logic [2:0] sz);
        case (sz)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic bit model_err(input bit w, input logic [2:0] sz, input int addr);
        int n;
        n = nbytes(sz);
        if (n == 0) return 1'b1;
        if (w && n < 4 && sz[2]) return 1'b1;
        return (addr % n) != 0;
    endfunction

    function automatic logic [31:0] model_read(input logic [2:0] sz, input int addr);
        longint v;
        int n;
        n = nbytes(sz);
        v = 0;
        for (int i = 0; i < n; i++) v += longint'(ref_mem[(addr + i) % 4096]) << (8 * i);
        if (!sz[2] && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    task automatic model_write(input logic [2:0] sz, input int addr, input logic [31:0] d);
        int n;
        n = nbytes(sz);
        for (int i = 0; i < n; i++) ref_mem[(addr + i) % 4096] = 8'((d >> (8 * i)) & 32'hFF);
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit p, input bit v, input bit w, input logic [2:0] sz,
                         input logic [11:0] a, input logic [31:0] d);
        if (p) begin
            m1_req_valid = v; m1_req_write = w; m1_req_size = sz; m1_req_addr = a; m1_req_wdata = d;
        end else begin
            m0_req_valid = v; m0_req_write = w; m0_req_size = sz; m0_req_addr = a; m0_req_wdata = d;
        end
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, " ctrl"}, {24'd0, m0_req_ready, m1_req_ready, m0_rsp_valid, m1_rsp_valid,
                              m0_rsp_err, m1_rsp_err, mem_write, |mem_size}, 32'd0);
        check({nm, " addr"}, {20'd0, mem_addr}, 32'd0);
        check({nm, " wdata"}, mem_wdata, 32'd0);
        check({nm, " rdata"}, m0_rsp_rdata | m1_rsp_rdata, 32'd0);
    endtask

    // One full transaction; called at posedge+1, returns at posedge+1 of the response cycle.
    task automatic do_access(input string nm, input bit p, input bit w, input logic [2:0] sz,
                             input logic [11:0] a, input logic [31:0] d,
                             input bit exp_err, input logic [31:0] exp_rd);
        bit got;
        drive(p, 1'b1, w, sz, a, d);
        #1;
        got = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if ((p ? m1_req_ready : m0_req_ready) === 1'b1) begin
                got = 1'b1;
                break;
            end
            tick();
            #1;
        end
        check({nm, " accepted"}, {31'd0, got}, 32'd1);
        check({nm, " other ready"}, {31'd0, p ? m0_req_ready : m1_req_ready}, 32'd0);
        check({nm, " wr in T"}, {31'd0, mem_write}, 32'd0);
        tick();
        drive(p, 1'b0, w, sz, a, d);
        #1;
        check({nm, " wr in T+1"}, {31'd0, mem_write}, {31'd0, w && !exp_err});
        check({nm, " mem_addr"}, {20'd0, mem_addr}, {20'd0, a});
        if (w && !exp_err) model_write(sz, int'(a), d);
        tick();
        check({nm, " rsp_valid"}, {30'd0, m1_rsp_valid, m0_rsp_valid}, p ? 32'd2 : 32'd1);
        check({nm, " rsp_err"}, {31'd0, p ? m1_rsp_err : m0_rsp_err}, {31'd0, exp_err});
        check({nm, " rsp_rdata"}, p ? m1_rsp_rdata : m0_rsp_rdata, exp_rd);
    endtask

    // Both ports request continuously; grants must alternate starting with m0.
    task automatic arb_run(input string nm, input int n);
        bit exp_p;
        bit got;
        exp_p = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 3'b010, 12'h010, 32'd0);
        drive(1'b1, 1'b1, 1'b0, 3'b010, 12'h020, 32'd0);
        #1;
        for (int k = 0; k < n; k++) begin
            got = 1'b0;
            for (int t = 0; t < 6; t++) begin
                check({nm, " one ready"}, {31'd0, m0_req_ready & m1_req_ready}, 32'd0);
                if (m0_req_ready || m1_req_ready) begin
                    got = 1'b1;
                    break;
                end
                tick();
                #1;
            end
            check($sformatf("%s grant %0d seen", nm, k), {31'd0, got}, 32'd1);
            check($sformatf("%s grant %0d port", nm, k), {31'd0, m1_req_ready}, {31'd0, exp_p});
            exp_p = ~exp_p;
            tick();
            #1;
            tick();
            #1;
        end
        m0_req_valid = 1'b0;
        m1_req_valid = 1'b0;
        tick();
    endtask

    typedef struct {
        bit          p;
        bit          w;
        logic [2:0]  sz;
        logic [11:0] a;
        logic [31:0] d;
        bit          err;
        logic [31:0] rd;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int nmis;
        for (int i = 0; i < 4096; i++) begin
            mem[i] = 8'd0;
            ref_mem[i] = 8'd0;
        end
        vecs[0]  = '{0, 1, 3'b010, 12'h010, 32'hDEADBEEF, 0, 32'h0};
        vecs[1]  = '{0, 0, 3'b010, 12'h010, 32'h0,        0, 32'hDEADBEEF};
        vecs[2]  = '{1, 1, 3'b000, 12'h021, 32'h00000080, 0, 32'h0};
        vecs[3]  = '{0, 0, 3'b000, 12'h021, 32'h0,        0, 32'hFFFFFF80};
        vecs[4]  = '{0, 0, 3'b100, 12'h021, 32'h0,        0, 32'h00000080};
        vecs[5]  = '{0, 0, 3'b010, 12'h002, 32'h0,        1, 32'h0};
        vecs[6]  = '{1, 1, 3'b001, 12'h005, 32'h0000A5A5, 1, 32'h0};
        vecs[7]  = '{0, 1, 3'b100, 12'h030, 32'h11223344, 1, 32'h0};
        vecs[8]  = '{1, 0, 3'b011, 12'h030, 32'h0,        1, 32'h0};
        vecs[9]  = '{1, 0, 3'b001, 12'h012, 32'h0,        0, 32'hFFFFDEAD};
        vecs[10] = '{0, 0, 3'b101, 12'h010, 32'h0,        0, 32'h0000BEEF};
        vecs[11] = '{1, 0, 3'b010, 12'h020, 32'h0,        0, 32'h00008000};

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 3'b000, 12'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 3'b000, 12'h0, 32'h0);
        tick();
        tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        arb_run("arb6", 6);

        for (int i = 0; i < 12; i++)
            do_access($sformatf("vec%0d", i), vecs[i].p, vecs[i].w, vecs[i].sz, vecs[i].a,
                      vecs[i].d, vecs[i].err, vecs[i].rd);

        for (int i = 0; i < 40; i++) begin
            bit          p, w;
            logic [2:0]  sz;
            logic [11:0] a;
            logic [31:0] d;
            bit          e;
            p  = 1'($urandom_range(0, 1));
            w  = 1'($urandom_range(0, 1));
            sz = 3'($urandom_range(0, 7));
            a  = 12'(12'h100 + $urandom_range(0, 15));
            d  = $urandom;
            e  = model_err(w, sz, int'(a));
            do_access($sformatf("rnd%0d", i), p, w, sz, a, d, e,
                      (w || e) ? 32'h0 : model_read(sz, int'(a)));
        end

        // Reset during the ACCESS cycle of a store.
        drive(1'b0, 1'b1, 1'b1, 3'b010, 12'h040, 32'h12345678);
        #1;
        check("rst seq accept", {31'd0, m0_req_ready}, 32'd1);
        tick();
        m0_req_valid = 1'b0;
        #1;
        check("rst seq write armed", {31'd0, mem_write}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid reset");
        tick();
        check("rst seq no rsp", {30'd0, m1_rsp_valid, m0_rsp_valid}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("rst seq no late rsp", {30'd0, m1_rsp_valid, m0_rsp_valid}, 32'd0);
        check("rst seq mem kept", {mem[12'h043], mem[12'h042], mem[12'h041], mem[12'h040]},
              {ref_mem[12'h043], ref_mem[12'h042], ref_mem[12'h041], ref_mem[12'h040]});

        arb_run("arb post-reset", 2);

        nmis = 0;
        for (int i = 0; i < 4096; i++) if (mem[i] !== ref_mem[i]) nmis++;
        check("memory image", 32'(nmis), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
